// File: rtl/cache_miss_ctrl.sv
// Miss/refill control FSM in front of a direct-mapped tag table: write-through, no write-allocate; CRITICAL_WORD_FIRST_EN starts refills at the requested word.
// Read hit: ready 2 cycles after req is sampled; misses and writes stall on mem_ack indefinitely, req is ignored while busy.
module cache_miss_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              MWr,
  input  logic [31:0]       AB,
  input  logic [DATA_W-1:0] DB,
  input  logic              hit,
  input  logic [DATA_W-1:0] cd_rdata,
  output logic              cd_we,
  output logic [15:0]       cd_addr,
  output logic [DATA_W-1:0] cd_wdata,
  output logic              WCT,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam logic [WB-1:0] LAST = WB'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL, FILL_WR, TAG, RESP, WRITE
  } state_t;

  state_t            state;
  logic [31:2]       ab_q;
  logic [DATA_W-1:0] db_q;
  logic              mwr_q;
  logic [WB-1:0]     wcnt;
  logic [WB-1:0]     nwords;
  logic [WB-1:0]     wnext;
  logic [WB-1:0]     first_w;
  logic              unused_ab;

  assign unused_ab = ^AB[1:0];
  assign wnext     = wcnt + 1'b1;
  assign cd_addr   = {ab_q[17:4], wcnt};

`ifdef CRITICAL_WORD_FIRST_EN
  assign first_w = ab_q[3:2];
`else
  assign first_w = '0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      ab_q      <= '0;
      db_q      <= '0;
      mwr_q     <= 1'b0;
      wcnt      <= '0;
      nwords    <= '0;
      cd_we     <= 1'b0;
      cd_wdata  <= '0;
      WCT       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ready     <= 1'b0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      cd_we <= 1'b0;
      WCT   <= 1'b0;
      ready <= 1'b0;
      case (state)
        // The ready cycle still sees the old req held high, so it must not start a new access.
        IDLE: if (req && !ready) begin
          ab_q  <= AB[31:2];
          db_q  <= DB;
          mwr_q <= MWr;
          wcnt  <= AB[3:2];
          busy  <= 1'b1;
          state <= LOOKUP;
        end
        LOOKUP: begin
          if (!mwr_q && hit) begin
            cpu_rdata <= cd_rdata;
            ready     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (!mwr_q) begin
            wcnt     <= first_w;
            nwords   <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {ab_q[31:4], first_w, 2'b00};
            state    <= REFILL;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {ab_q, 2'b00};
            mem_wdata <= db_q;
            cd_we     <= hit;
            cd_wdata  <= db_q;
            state     <= WRITE;
          end
        end
        REFILL: if (mem_req && mem_ack) begin
          mem_req  <= 1'b0;
          cd_we    <= 1'b1;
          cd_wdata <= mem_rdata;
          if (wcnt == ab_q[3:2]) cpu_rdata <= mem_rdata;
          state    <= FILL_WR;
        end
        // Counter advances only after the data write so cd_addr still names the word being written.
        FILL_WR: begin
          wcnt   <= wnext;
          nwords <= nwords + 1'b1;
          if (nwords == LAST) begin
            WCT   <= 1'b1;
            state <= TAG;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {ab_q[31:4], wnext, 2'b00};
            state    <= REFILL;
          end
        end
        TAG: begin
          ready <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        WRITE: if (mem_req && mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
- Control FSM that sits directly upstream of the direct-mapped cache tag table.
- Accepts CPU access requests, samples the table's combinational hit, and serves read hits from cache data RAM.
- Read miss: refills the 4-word (16-byte) line from main memory, then pulses WCT so the table records tag AB[31:18] at index AB[17:4] as valid.
- Writes: write-through, no write-allocate.

Parameters:
LINE_WORDS  4  words per line; fixed at 4 to match offset AB[3:2] and index AB[17:4]
DATA_W  32  CPU/memory data width

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  reset, asynchronous, active-high
req  in  1  CPU access request; held with AB/DB/MWr stable until ready
MWr  in  1  1 = write, 0 = read (sampled with req)
AB  in  32  CPU byte address; routed unchanged to tag table
DB  in  32  CPU write data
hit  in  1  tag table hit (combinational from AB)
cd_rdata  in  32  cache data RAM read data for cd_addr (combinational)
cd_we  out  1  cache data RAM word write enable
cd_addr  out  16  cache data word address {AB[17:4], word}
cd_wdata  out  32  cache data write data
WCT  out  1  tag-table write strobe, one-cycle pulse
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write qualifier
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  memory write data
mem_ack  in  1  memory acknowledge, one-cycle pulse; mem_rdata valid same cycle
mem_rdata  in  32  memory read data
ready  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  32  read result; valid while ready=1, held until next read completes
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered except cd_addr, which is combinational from the latched index and word counter. Reset values: all outputs 0, FSM in IDLE, word counter 0.
- IDLE: req=1 → latch AB, DB, MWr; go to LOOKUP. req is ignored in all other states.
- LOOKUP: one cycle; hit sampled at its end.
  - Read and hit → cpu_rdata←cd_rdata; ready=1 next cycle; go to IDLE. Read-hit latency: ready 2 cycles after the req-sampling edge.
  - Read and miss → REFILL.
  - Write → WRITE.
- REFILL: for each word w:
  - Drive mem_req=1, mem_we=0, mem_addr={AB[31:4], w, 2'b00}.
  - On mem_ack: drop mem_req; cd_we=1 for one cycle with cd_wdata=mem_rdata and cd_addr={AB[17:4], w}.
  - If w==AB[3:2], capture mem_rdata into cpu_rdata.
  - Counter increments modulo 4. After the 4th word → TAG.
  - mem_req deasserts for at least one cycle between words.
- TAG: WCT=1 for exactly one cycle → RESP.
- RESP: ready=1 for one cycle → IDLE. Tag table must report hit=1 for the same AB from the following cycle.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr={AB[31:2], 2'b00}, mem_wdata=DB.
  - If hit was sampled 1 in LOOKUP: cd_we=1 for one cycle at entry with cd_wdata=DB, cd_addr={AB[17:4], AB[3:2]}.
  - On mem_ack: drop mem_req; ready=1 next cycle → IDLE.
  - Write miss: no WCT, no cache data write.
- Memory handshake:
  - mem_ack counts only when mem_req=1; stray acks are ignored.
  - mem_ack in the same cycle mem_req first rises is valid.
  - No timeout; FSM waits indefinitely.
- clr asserted at any time (including mid-refill with mem_req high): immediate return to IDLE, all outputs 0.
  - Partially refilled line is left untagged, because WCT never fired.
  - A late mem_ack after clr deasserts is ignored.
- Ready is never asserted on the same cycle as WCT.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: refill begins at word AB[3:2] and wraps modulo 4 (e.g. offset 2 → order 2,3,0,1). cpu_rdata is captured from the first mem_ack.
- Undefined: refill order is always 0,1,2,3.
- All other timing is unchanged in both cases.

Test Plan:
- Reset, then read AB=0x0000_1230 with table empty, memory words 0xA0..0xA3 → 4 mem_req reads at 0x1230,0x1234,0x1238,0x123C; 4 cd_we pulses; one WCT pulse; ready with cpu_rdata=0xA0; hit=1 on the next cycle.
- Repeat the same read with cd_rdata=0xA0 → no mem_req; ready 2 cycles after req; cpu_rdata=0xA0.
- Write AB=0x0000_1234, DB=0xDEAD_BEEF on a hit → cd_we with cd_addr=0x0123·4+1; one mem_req with mem_we=1, mem_wdata=0xDEADBEEF; ready after mem_ack; no WCT.
- Write miss at AB=0x0004_1234 (same index, different tag) → memory write only; no cd_we, no WCT.
- Assert clr after the 2nd refill ack → all outputs 0 at once; a later mem_ack is ignored; reading the same address misses and refills from word 0.
- With CRITICAL_WORD_FIRST_EN, read AB=0x0000_5678 → refill addresses 0x5678,0x567C,0x5670,0x5674; cpu_rdata equals the first mem_rdata.
